load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU; the ALU result (y) is the effective address.
- Accepts one load/store request at a time.
- Checks alignment and drives a request/acknowledge data-memory bus with byte strobes.
- For loads, extracts and sign/zero-extends the addressed byte/half/word.
- Returns one response per request, with an error code for misalignment or bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in BUS waiting for mem_ack; 0 disables timeout
CNT_WIDTH, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when req_valid&req_ready
req_store  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal (treated as misaligned)
req_unsigned  in  1  load zero-extend (lbu/lhu); ignored for stores and words
req_addr  in  `word_width  effective address (ALU y)
req_wdata  in  `word_width  store data (rs2), value in low bits
resp_valid  out  1  one-cycle response pulse
resp_err  out  2  0=ok, 1=misaligned, 2=timeout
resp_rdata  out  `word_width  extended load data; 0 for stores and errors
mem_req  out  1  bus request, held until ack or timeout
mem_we  out  1  write enable
mem_addr  out  `word_width  word-aligned address (req_addr with [1:0]=0)
mem_wstrb  out  4  byte-lane strobes
mem_wdata  out  `word_width  lane-replicated store data
mem_ack  in  1  bus completion; mem_rdata valid in the same cycle for loads
mem_rdata  in  `word_width  read word

Behaviour:
- Reset values:
  - req_ready=0; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_req=0; mem_we=0; mem_addr=0; mem_wstrb=0; mem_wdata=0.
  - FSM in IDLE; timeout counter cleared.
- All outputs are registered except req_ready, which is decoded combinationally as state==IDLE.
- Reset asserted mid-operation: mem_req drops immediately (async), and any pending response is discarded.
- FSM states IDLE, BUS, RESP.
- IDLE, accept (req_valid=1):
  - Latch store flag, size, unsigned flag and addr[1:0].
  - Misaligned when: half with addr[0]=1; word with addr[1:0]!=0; or size=3.
  - Misaligned -> RESP with resp_err=1; no bus cycle.
  - Otherwise -> BUS; next cycle mem_req=1 with mem_addr, mem_we, mem_wstrb, mem_wdata set.
- BUS:
  - Outputs held stable while mem_req=1; counter increments each cycle.
  - mem_ack=1 -> mem_req=0 next cycle, go to RESP. For loads, capture the extracted data at the ack edge.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack (TIMEOUT_CYCLES>0) -> mem_req=0, resp_err=2, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No backpressure; the consumer must take the pulse.
- Latency: accept at edge N, mem_req high in cycle N+1. With ack in cycle N+1, resp_valid is high in cycle N+2.
- mem_ack outside BUS is ignored.
- Store lanes, with o=addr[1:0]:
  - byte: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - half: wstrb=4'b0011<<{o[1],0}, wdata={2{wdata[15:0]}}.
  - word: wstrb=4'b1111, wdata=wdata.
- Loads: mem_wstrb=0 and mem_we=0. Take sh=mem_rdata>>(8*o), then:
  - byte: sign- or zero-extend sh[7:0].
  - half: sign- or zero-extend sh[15:0].
  - word: mem_rdata unchanged.
- resp_rdata=0 for stores and for errors.

Decomposition:
- Add to parameters.vh:
  - size codes: size_byte, size_half, size_word.
  - error codes: lsu_ok, lsu_misaligned, lsu_timeout.
  - state encodings: lsu_idle, lsu_bus, lsu_resp.
  - strobe width: wstrb_width = `word_width/8.
- One combinational sub-module, lsu_lane_align, holds both directions: store strobe/replication and load extract/extend. This keeps the FSM file pure control.

Test Plan:
- Load byte signed: addr=0x103, mem_rdata=0x80FF_1234, ack in first BUS cycle -> mem_addr=0x100, wstrb=0, resp_rdata=0xFFFFFF80, err=0, resp_valid 2 cycles after accept.
- Load half unsigned: addr=0x202, mem_rdata=0xBEEF_0000 -> resp_rdata=0x0000BEEF.
- Store half: addr=0x302, wdata=0x1234ABCD -> mem_we=1, wstrb=4'b1100, mem_wdata=0xABCDABCD, resp_rdata=0.
- Misaligned word load: addr=0x401 -> mem_req never asserts, resp_valid next cycle, err=1.
- Timeout: ack never returned, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then err=2, resp_rdata=0. Repeat with ack in the 16th cycle -> err=0.
- Reset mid-BUS: rst_n low while mem_req=1 -> mem_req=0 without a clock edge, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: word geometry,
// access size codes, response error codes and FSM state encodings.
package load_store_unit_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int WSTRB_WIDTH = WORD_WIDTH / 8;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        LSU_OK         = 2'd0,
        LSU_MISALIGNED = 2'd1,
        LSU_TIMEOUT    = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } state_e;

    // An access is misaligned if it does not sit on its natural boundary;
    // the reserved size code is folded into the same error.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering for both directions: store strobes and data
// replication, and load extraction with sign/zero extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]             size_i,
    input  logic [1:0]             off_i,
    input  logic                   unsigned_i,
    input  logic [WORD_WIDTH-1:0]  wdata_i,
    input  logic [WORD_WIDTH-1:0]  rdata_i,
    output logic [WSTRB_WIDTH-1:0] wstrb_o,
    output logic [WORD_WIDTH-1:0]  wdata_o,
    output logic [WORD_WIDTH-1:0]  rdata_o
);

    logic [WORD_WIDTH-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    // Store side: strobe the addressed lanes, replicate data across all lanes.
    always_comb begin
        wstrb_o = '0;
        wdata_o = '0;
        case (size_e'(size_i))
            SIZE_BYTE: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                wstrb_o = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed bytes down to bit 0 and extend.
    always_comb begin
        rdata_o = '0;
        case (size_e'(size_i))
            SIZE_BYTE: rdata_o = unsigned_i ? {24'b0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: rdata_o = unsigned_i ? {16'b0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: rdata_o = rdata_i;
            default:   ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from the ALU stage, runs a
// req/ack data-memory cycle with byte strobes, and returns one response.
//
// Handshakes: a request is accepted on a rising edge where
// req_valid_i && req_ready_o; req_ready_o is high only in IDLE. mem_req_o
// and the bus fields stay stable until the edge that samples mem_ack_i (or
// a timeout). resp_valid_o is a single-cycle pulse with no backpressure.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_store_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [WORD_WIDTH-1:0]  req_addr_i,
    input  logic [WORD_WIDTH-1:0]  req_wdata_i,
    output logic                   resp_valid_o,
    output logic [1:0]             resp_err_o,
    output logic [WORD_WIDTH-1:0]  resp_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WORD_WIDTH-1:0]  mem_addr_o,
    output logic [WSTRB_WIDTH-1:0] mem_wstrb_o,
    output logic [WORD_WIDTH-1:0]  mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [WORD_WIDTH-1:0]  mem_rdata_i,
    output logic [1:0]             dbg_state_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic                   store_q, store_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [1:0]             off_q, off_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WSTRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [WORD_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [1:0]             resp_err_q, resp_err_d;
    logic [WORD_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;

    logic                   accept_misaligned;
    logic                   timeout;
    logic [1:0]             align_size;
    logic [1:0]             align_off;
    logic [WSTRB_WIDTH-1:0] align_wstrb;
    logic [WORD_WIDTH-1:0]  align_wdata;
    logic [WORD_WIDTH-1:0]  align_rdata;

    assign accept_misaligned = is_misaligned(size_e'(req_size_i), req_addr_i[1:0]);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // In IDLE the aligner sees the incoming request (store lanes); afterwards
    // it sees the latched request (load extraction at the ack edge).
    assign align_size = (state_q == LSU_IDLE) ? req_size_i : size_q;
    assign align_off  = (state_q == LSU_IDLE) ? req_addr_i[1:0] : off_q;

    lsu_lane_align u_align (
        .size_i     (align_size),
        .off_i      (align_off),
        .unsigned_i (uns_q),
        .wdata_i    (req_wdata_i),
        .rdata_i    (mem_rdata_i),
        .wstrb_o    (align_wstrb),
        .wdata_o    (align_wdata),
        .rdata_o    (align_rdata)
    );

    // Gated by reset so the port reads 0 while the unit is held in reset.
    assign req_ready_o  = rst_ni && (state_q == LSU_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign dbg_state_o  = state_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= LSU_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode; ack takes priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (req_valid_i) state_d = accept_misaligned ? LSU_RESP : LSU_BUS;
            LSU_BUS:  if (mem_ack_i || timeout) state_d = LSU_RESP;
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Next values of the registered outputs and request context.
    always_comb begin
        store_d      = store_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i) begin
                    store_d = req_store_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    off_d   = req_addr_i[1:0];
                    cnt_d   = '0;
                    if (accept_misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = LSU_MISALIGNED;
                        resp_rdata_d = '0;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store_i;
                        mem_addr_d  = {req_addr_i[WORD_WIDTH-1:2], 2'b00};
                        mem_wstrb_d = req_store_i ? align_wstrb : '0;
                        mem_wdata_d = req_store_i ? align_wdata : '0;
                    end
                end
            end
            LSU_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack_i || timeout) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = mem_ack_i ? LSU_OK : LSU_TIMEOUT;
                    resp_rdata_d = (mem_ack_i && !store_q) ? align_rdata : '0;
                end
            end
            LSU_RESP: begin
                resp_err_d   = LSU_OK;
                resp_rdata_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset drops mem_req and any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 2'b00;
            resp_rdata_q <= '0;
        end else begin
            store_q      <= store_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit with a byte-level
// reference model of alignment, strobes, replication and extension.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_store_i    (req_store),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_err_o     (resp_err),
        .resp_rdata_o   (resp_rdata),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wstrb_o    (mem_wstrb),
        .mem_wdata_o    (mem_wdata),
        .mem_ack_i      (mem_ack),
        .mem_rdata_i    (mem_rdata),
        .dbg_state_o    (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input int size);
        return 1 << size;
    endfunction

    function automatic bit m_misaligned(input int size, input logic [31:0] addr);
        if (size == 3) return 1'b1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input int size, input int off);
        int m;
        m = ((1 << nbytes(size)) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input int size, input bit uns, input int off,
                                           input logic [31:0] rd);
        longint v;
        int bits;
        if (size == 2) return rd;
        bits = 8 * nbytes(size);
        v = (longint'(rd) >> (8 * off)) & ((longint'(1) << bits) - 1);
        if (!uns && v[bits-1]) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    // ack_after: number of mem_req cycles before the one carrying the ack;
    // negative means never acknowledge.
    task automatic do_req(input string tag, input bit st, input int size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_after, input logic [31:0] rd);
        int n;
        int exp_n;
        bit mis;
        int off;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        mis = m_misaligned(size, addr);
        off = int'(addr[1:0]);
        @(negedge clk);
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_size = size[1:0];
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (mis) begin
            check({tag, " mis_req"}, {31'b0, mem_req}, 32'd0);
            check({tag, " mis_valid"}, {31'b0, resp_valid}, 32'd1);
            check({tag, " mis_err"}, {30'b0, resp_err}, 32'd1);
            check({tag, " mis_rdata"}, resp_rdata, 32'd0);
        end else begin
            n = 0;
            while (mem_req === 1'b1 && n < 40) begin
                if (n == 0) begin
                    check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
                    check({tag, " we"}, {31'b0, mem_we}, {31'b0, st});
                    check({tag, " wstrb"}, {28'b0, mem_wstrb}, st ? {28'b0, m_strb(size, off)} : 32'd0);
                    if (st) check({tag, " wdata"}, mem_wdata, m_wdata(size, wd));
                end
                mem_ack = (n == ack_after);
                mem_rdata = (n == ack_after) ? rd : $urandom;
                n++;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            exp_n = (ack_after >= 0 && ack_after < TO) ? ack_after + 1 : TO;
            exp_err = (ack_after >= 0 && ack_after < TO) ? 2'd0 : 2'd2;
            exp_rdata = (exp_err == 2'd0 && !st) ? m_load(size, uns, off, rd) : 32'd0;
            check({tag, " req_cycles"}, n, exp_n);
            check({tag, " valid"}, {31'b0, resp_valid}, 32'd1);
            check({tag, " err"}, {30'b0, resp_err}, {30'b0, exp_err});
            check({tag, " rdata"}, resp_rdata, exp_rdata);
        end
        @(negedge clk);
        check({tag, " pulse_end"}, {31'b0, resp_valid}, 32'd0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int sz;
        int ack;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst mem_req", {31'b0, mem_req}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_req("lb_signed", 0, 0, 0, 32'h103, 32'h0, 0, 32'h80FF_1234);
        do_req("lhu", 0, 1, 1, 32'h202, 32'h0, 0, 32'hBEEF_0000);
        do_req("sh", 1, 1, 0, 32'h302, 32'h1234_ABCD, 0, 32'h0);
        do_req("lw_mis", 0, 2, 0, 32'h401, 32'h0, 0, 32'h0);
        do_req("size3", 1, 3, 0, 32'h500, 32'h0, 0, 32'h0);
        do_req("timeout", 0, 2, 0, 32'h600, 32'h0, -1, 32'h0);
        do_req("ack_last", 0, 2, 0, 32'h604, 32'h0, TO - 1, 32'hCAFE_F00D);
        do_req("sw_late", 1, 2, 0, 32'h700, 32'hDEAD_BEEF, 3, 32'h0);

        // Stray ack while idle must not produce a response.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack valid", {31'b0, resp_valid}, 32'd0);
        check("stray_ack ready", {31'b0, req_ready}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            sz = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && sz < 3) a = a & ~(nbytes(sz) - 1);
            ack = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
            do_req("rand", $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
                   a, $urandom, ack, $urandom);
        end

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h800;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst req_before", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst req_async", {31'b0, mem_req}, 32'd0);
        check("midrst valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
                check("midrst quiet", {30'b0, resp_valid, mem_req}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        check("midrst quiet_end", {30'b0, resp_valid, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
